// File: rtl/tlb_test_top_pkg.sv
// Shared TLB geometry, harness phase encoding and the per-entry test pattern.
package tlb_test_top_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  // Cache attribute written to every page of every entry.
  localparam logic [C_W-1:0] EXP_C = 3'd3;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_WRITE  = 3'd1,
    PH_READ   = 3'd2,
    PH_SEARCH = 3'd3,
    PH_DONE   = 3'd4
  } phase_e;

  function automatic logic [VPN2_W-1:0] exp_vpn2(input logic [IDX_W-1:0] i);
    return {15'h0, i};
  endfunction

  function automatic logic [ASID_W-1:0] exp_asid(input logic [IDX_W-1:0] i);
    return {4'h0, i};
  endfunction

  // i[3] & i[2] is the same set as i >= 12: entries 12..15 are global.
  function automatic logic exp_g(input logic [IDX_W-1:0] i);
    return (i >= 4'd12);
  endfunction

  function automatic logic [PFN_W-1:0] exp_pfn0(input logic [IDX_W-1:0] i);
    return {16'h0000, i};
  endfunction

  function automatic logic [PFN_W-1:0] exp_pfn1(input logic [IDX_W-1:0] i);
    return {16'h1000, i};
  endfunction

  // Dirty bits alternate with the entry parity; the odd page gets the inverse.
  function automatic logic exp_d0(input logic idx_lsb);
    return idx_lsb;
  endfunction

  function automatic logic exp_d1(input logic idx_lsb);
    return ~idx_lsb;
  endfunction

  // OR-based encoder; exact only for one-hot (or all-zero) inputs.
  function automatic logic [IDX_W-1:0] onehot2bin(input logic [TLBNUM-1:0] oh);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int k = 0; k < TLBNUM; k++) begin
      if (oh[k]) b = b | k[IDX_W-1:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/tlb_test_top_tlb.sv
// 16-entry TLB: one write port, one combinational read port and two
// combinational search ports. Contents clear on reset.
module tlb
  import tlb_test_top_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  // write port
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  // read port
  input  logic [IDX_W-1:0]  r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1,
  // search port 0
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDX_W-1:0]  s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,
  // search port 1
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDX_W-1:0]  s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v
);

  logic [TLBNUM-1:0][VPN2_W-1:0] r_tlb_vpn2;
  logic [TLBNUM-1:0][ASID_W-1:0] r_tlb_asid;
  logic [TLBNUM-1:0]             r_tlb_g;
  logic [TLBNUM-1:0][PFN_W-1:0]  r_tlb_pfn0;
  logic [TLBNUM-1:0][C_W-1:0]    r_tlb_c0;
  logic [TLBNUM-1:0]             r_tlb_d0;
  logic [TLBNUM-1:0]             r_tlb_v0;
  logic [TLBNUM-1:0][PFN_W-1:0]  r_tlb_pfn1;
  logic [TLBNUM-1:0][C_W-1:0]    r_tlb_c1;
  logic [TLBNUM-1:0]             r_tlb_d1;
  logic [TLBNUM-1:0]             r_tlb_v1;

  logic [TLBNUM-1:0] w_s0_match;
  logic [TLBNUM-1:0] w_s1_match;

  // Entry storage: cleared on reset, one entry updated per write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tlb_vpn2 <= '0;
      r_tlb_asid <= '0;
      r_tlb_g    <= '0;
      r_tlb_pfn0 <= '0;
      r_tlb_c0   <= '0;
      r_tlb_d0   <= '0;
      r_tlb_v0   <= '0;
      r_tlb_pfn1 <= '0;
      r_tlb_c1   <= '0;
      r_tlb_d1   <= '0;
      r_tlb_v1   <= '0;
    end else if (we) begin
      r_tlb_vpn2[w_index] <= w_vpn2;
      r_tlb_asid[w_index] <= w_asid;
      r_tlb_g[w_index]    <= w_g;
      r_tlb_pfn0[w_index] <= w_pfn0;
      r_tlb_c0[w_index]   <= w_c0;
      r_tlb_d0[w_index]   <= w_d0;
      r_tlb_v0[w_index]   <= w_v0;
      r_tlb_pfn1[w_index] <= w_pfn1;
      r_tlb_c1[w_index]   <= w_c1;
      r_tlb_d1[w_index]   <= w_d1;
      r_tlb_v1[w_index]   <= w_v1;
    end
  end

  assign r_vpn2 = r_tlb_vpn2[r_index];
  assign r_asid = r_tlb_asid[r_index];
  assign r_g    = r_tlb_g[r_index];
  assign r_pfn0 = r_tlb_pfn0[r_index];
  assign r_c0   = r_tlb_c0[r_index];
  assign r_d0   = r_tlb_d0[r_index];
  assign r_v0   = r_tlb_v0[r_index];
  assign r_pfn1 = r_tlb_pfn1[r_index];
  assign r_c1   = r_tlb_c1[r_index];
  assign r_d1   = r_tlb_d1[r_index];
  assign r_v1   = r_tlb_v1[r_index];

  // Per-entry match: global entries ignore the ASID.
  genvar gi;
  generate
    for (gi = 0; gi < TLBNUM; gi++) begin : g_match
      assign w_s0_match[gi] = (r_tlb_vpn2[gi] == s0_vpn2) &&
                              (r_tlb_g[gi] || (r_tlb_asid[gi] == s0_asid));
      assign w_s1_match[gi] = (r_tlb_vpn2[gi] == s1_vpn2) &&
                              (r_tlb_g[gi] || (r_tlb_asid[gi] == s1_asid));
    end
  endgenerate

  // Miss results come from entry 0 and are meaningless; callers gate on found.
  assign s0_found = |w_s0_match;
  assign s0_index = onehot2bin(w_s0_match);
  assign s0_pfn   = s0_odd_page ? r_tlb_pfn1[s0_index] : r_tlb_pfn0[s0_index];
  assign s0_c     = s0_odd_page ? r_tlb_c1[s0_index]   : r_tlb_c0[s0_index];
  assign s0_d     = s0_odd_page ? r_tlb_d1[s0_index]   : r_tlb_d0[s0_index];
  assign s0_v     = s0_odd_page ? r_tlb_v1[s0_index]   : r_tlb_v0[s0_index];

  assign s1_found = |w_s1_match;
  assign s1_index = onehot2bin(w_s1_match);
  assign s1_pfn   = s1_odd_page ? r_tlb_pfn1[s1_index] : r_tlb_pfn0[s1_index];
  assign s1_c     = s1_odd_page ? r_tlb_c1[s1_index]   : r_tlb_c0[s1_index];
  assign s1_d     = s1_odd_page ? r_tlb_d1[s1_index]   : r_tlb_d0[s1_index];
  assign s1_v     = s1_odd_page ? r_tlb_v1[s1_index]   : r_tlb_v0[s1_index];

endmodule

// File: rtl/tlb_test_top.sv
// On-chip TLB test harness: write pattern, read back, dual-port search.
// Results are exposed only as sticky internal flags for probing.
module tlb_test_top
  import tlb_test_top_pkg::*;
#(
  parameter bit SIMULATION = 1'b1
) (
  input logic clk,
  input logic resetn
);

  // Hardware runs wait 2^24 cycles so a debugger can attach before the test.
  localparam logic [24:0] START_DELAY = SIMULATION ? 25'd0 : 25'h100_0000;

  phase_e      r_phase;
  logic [24:0] r_delay_cnt;
  logic [4:0]  w_cnt;
  logic [4:0]  tlb_r_cnt;
  logic [4:0]  s0_test_id;
  logic [4:0]  s1_test_id;
  logic        tlb_w_test_ok;
  logic        tlb_r_test_ok;
  logic        tlb_s_test_ok;
  logic        test_error;

  logic w_start;
  logic w_in_write;
  logic w_we;
  logic w_rd_ok;
  logic w_s0_ok;
  logic w_s1_ok;

  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;
  logic [IDX_W-1:0]  w_s0k;
  logic [IDX_W-1:0]  w_s1k;

  logic [VPN2_W-1:0] w_vpn2;
  logic [ASID_W-1:0] w_asid;
  logic              w_g;
  logic [PFN_W-1:0]  w_pfn0;
  logic [PFN_W-1:0]  w_pfn1;
  logic              w_d0;
  logic              w_d1;

  logic [VPN2_W-1:0] r_vpn2;
  logic [ASID_W-1:0] r_asid;
  logic              r_g;
  logic [PFN_W-1:0]  r_pfn0;
  logic [C_W-1:0]    r_c0;
  logic              r_d0;
  logic              r_v0;
  logic [PFN_W-1:0]  r_pfn1;
  logic [C_W-1:0]    r_c1;
  logic              r_d1;
  logic              r_v1;

  logic              s0_found;
  logic [IDX_W-1:0]  s0_index;
  logic [PFN_W-1:0]  s0_pfn;
  logic [C_W-1:0]    s0_c;
  logic              s0_d;
  logic              s0_v;
  logic              s1_found;
  logic [IDX_W-1:0]  s1_index;
  logic [PFN_W-1:0]  s1_pfn;
  logic [C_W-1:0]    s1_c;
  logic              s1_d;
  logic              s1_v;

  assign w_widx = w_cnt[IDX_W-1:0];
  assign w_ridx = tlb_r_cnt[IDX_W-1:0];
  assign w_s0k  = s0_test_id[IDX_W-1:0];
  assign w_s1k  = s1_test_id[IDX_W-1:0];

  // IDLE doubles as the first write cycle once the delay has elapsed, so
  // entry 0 is written on the very first edge after reset release.
  assign w_start    = (r_delay_cnt == START_DELAY);
  assign w_in_write = (r_phase == PH_WRITE) || ((r_phase == PH_IDLE) && w_start);
  assign w_we       = w_in_write && !test_error;

  assign w_vpn2 = exp_vpn2(w_widx);
  assign w_asid = exp_asid(w_widx);
  assign w_g    = exp_g(w_widx);
  assign w_pfn0 = exp_pfn0(w_widx);
  assign w_pfn1 = exp_pfn1(w_widx);
  assign w_d0   = exp_d0(w_widx[0]);
  assign w_d1   = exp_d1(w_widx[0]);

  // Field-by-field check of the entry currently on the read port.
  assign w_rd_ok = (r_vpn2 == exp_vpn2(w_ridx)) && (r_asid == exp_asid(w_ridx)) &&
                   (r_g == exp_g(w_ridx)) &&
                   (r_pfn0 == exp_pfn0(w_ridx)) && (r_c0 == EXP_C) &&
                   (r_d0 == exp_d0(w_ridx[0])) && r_v0 &&
                   (r_pfn1 == exp_pfn1(w_ridx)) && (r_c1 == EXP_C) &&
                   (r_d1 == exp_d1(w_ridx[0])) && r_v1;

  // Port 0 always hits its own entry; odd vectors select the odd page.
  assign w_s0_ok = s0_found && (s0_index == w_s0k) &&
                   (s0_pfn == (w_s0k[0] ? exp_pfn1(w_s0k) : exp_pfn0(w_s0k))) &&
                   (s0_c == EXP_C) &&
                   (s0_d == (w_s0k[0] ? exp_d1(w_s0k[0]) : exp_d0(w_s0k[0]))) &&
                   s0_v;

  // Port 1 uses a foreign ASID, so only the global entries may hit.
  assign w_s1_ok = exp_g(w_s1k) ?
                   (s1_found && (s1_index == w_s1k) && (s1_pfn == exp_pfn0(w_s1k)) &&
                    (s1_c == EXP_C) && (s1_d == exp_d0(w_s1k[0])) && s1_v) :
                   !s1_found;

  // Phase sequencer; any detected error freezes every counter and flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase       <= PH_IDLE;
      r_delay_cnt   <= '0;
      w_cnt         <= '0;
      tlb_r_cnt     <= '0;
      s0_test_id    <= '0;
      s1_test_id    <= '0;
      tlb_w_test_ok <= 1'b0;
      tlb_r_test_ok <= 1'b0;
      tlb_s_test_ok <= 1'b0;
      test_error    <= 1'b0;
    end else if (!test_error) begin
      case (r_phase)
        PH_IDLE, PH_WRITE: begin
          if (w_in_write) begin
            w_cnt <= w_cnt + 5'd1;
            if (w_cnt == 5'd15) begin
              tlb_w_test_ok <= 1'b1;
              r_phase       <= PH_READ;
            end else begin
              r_phase <= PH_WRITE;
            end
          end else begin
            r_delay_cnt <= r_delay_cnt + 25'd1;
          end
        end
        PH_READ: begin
          if (!w_rd_ok) begin
            test_error <= 1'b1;
          end else begin
            tlb_r_cnt <= tlb_r_cnt + 5'd1;
            if (tlb_r_cnt == 5'd15) begin
              tlb_r_test_ok <= 1'b1;
              r_phase       <= PH_SEARCH;
            end
          end
        end
        PH_SEARCH: begin
          if (!(w_s0_ok && w_s1_ok)) begin
            test_error <= 1'b1;
          end else begin
            s0_test_id <= s0_test_id + 5'd1;
            s1_test_id <= s1_test_id + 5'd1;
            if ((s0_test_id == 5'd15) && (s1_test_id == 5'd15)) begin
              tlb_s_test_ok <= 1'b1;
              r_phase       <= PH_DONE;
            end
          end
        end
        PH_DONE: r_phase <= PH_DONE;
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  tlb u_tlb (
    .clk        (clk),
    .resetn     (resetn),
    .we         (w_we),
    .w_index    (w_widx),
    .w_vpn2     (w_vpn2),
    .w_asid     (w_asid),
    .w_g        (w_g),
    .w_pfn0     (w_pfn0),
    .w_c0       (EXP_C),
    .w_d0       (w_d0),
    .w_v0       (1'b1),
    .w_pfn1     (w_pfn1),
    .w_c1       (EXP_C),
    .w_d1       (w_d1),
    .w_v1       (1'b1),
    .r_index    (w_ridx),
    .r_vpn2     (r_vpn2),
    .r_asid     (r_asid),
    .r_g        (r_g),
    .r_pfn0     (r_pfn0),
    .r_c0       (r_c0),
    .r_d0       (r_d0),
    .r_v0       (r_v0),
    .r_pfn1     (r_pfn1),
    .r_c1       (r_c1),
    .r_d1       (r_d1),
    .r_v1       (r_v1),
    .s0_vpn2    (exp_vpn2(w_s0k)),
    .s0_odd_page(w_s0k[0]),
    .s0_asid    (exp_asid(w_s0k)),
    .s0_found   (s0_found),
    .s0_index   (s0_index),
    .s0_pfn     (s0_pfn),
    .s0_c       (s0_c),
    .s0_d       (s0_d),
    .s0_v       (s0_v),
    .s1_vpn2    (exp_vpn2(w_s1k)),
    .s1_odd_page(1'b0),
    .s1_asid    (8'hFF),
    .s1_found   (s1_found),
    .s1_index   (s1_index),
    .s1_pfn     (s1_pfn),
    .s1_c       (s1_c),
    .s1_d       (s1_d),
    .s1_v       (s1_v)
  );

endmodule

// File: tb/tb_tlb_test_top.sv
// Directed bench for the TLB test harness: nominal run, mid-run reset and
// an injected stored-data fault, observed through the harness probe signals.
module tb_tlb_test_top;

  logic clk;
  logic resetn;

  int n_checks;
  int n_errors;
  int cyc;

  logic [319:0] fault_pfn0;

  tlb_test_top #(.SIMULATION(1'b1)) dut (
    .clk   (clk),
    .resetn(resetn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %-22s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, expv);
    end else begin
      $display("ok   %-22s cyc=%0d value=0x%0h", tag, cyc, obs);
    end
  endtask

  // Advance n rising edges and sample 1 ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_flags(input string tag, input logic w, input logic r, input logic s);
    check({tag, ".w_ok"}, 32'(dut.tlb_w_test_ok), 32'(w));
    check({tag, ".r_ok"}, 32'(dut.tlb_r_test_ok), 32'(r));
    check({tag, ".s_ok"}, 32'(dut.tlb_s_test_ok), 32'(s));
  endtask

  // Release reset on a falling edge so edge 1 is the first active cycle.
  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    resetn   = 1'b0;

    // Reset state while held low.
    #1000;
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset.err", 32'(dut.test_error), 32'd0);
    check("reset.r_cnt", 32'(dut.tlb_r_cnt), 32'd0);
    check("reset.s0_id", 32'(dut.s0_test_id), 32'd0);
    check("reset.tlb_pfn1[0]", 32'(dut.r_pfn1), 32'd0);
    #1000;
    release_reset();

    // Nominal sequence.
    tick(15);
    check("c15.w_ok", 32'(dut.tlb_w_test_ok), 32'd0);
    tick(1);
    check("c16.w_ok", 32'(dut.tlb_w_test_ok), 32'd1);
    check("c16.r_ok", 32'(dut.tlb_r_test_ok), 32'd0);
    tick(13);
    check("rd13.r_cnt", 32'(dut.tlb_r_cnt), 32'd13);
    check("rd13.r_pfn1", 32'(dut.r_pfn1), 32'h1000D);
    check("rd13.r_g", 32'(dut.r_g), 32'd1);
    check("rd13.r_d0", 32'(dut.r_d0), 32'd1);
    check("rd13.r_d1", 32'(dut.r_d1), 32'd0);
    tick(2);
    check("c31.r_ok", 32'(dut.tlb_r_test_ok), 32'd0);
    tick(1);
    check("c32.r_ok", 32'(dut.tlb_r_test_ok), 32'd1);
    check("c32.r_cnt", 32'(dut.tlb_r_cnt), 32'd16);
    tick(5);
    check("s0v5.id", 32'(dut.s0_test_id), 32'd5);
    check("s0v5.found", 32'(dut.s0_found), 32'd1);
    check("s0v5.index", 32'(dut.s0_index), 32'd5);
    check("s0v5.pfn", 32'(dut.s0_pfn), 32'h10005);
    check("s0v5.d", 32'(dut.s0_d), 32'd0);
    tick(6);
    check("s1v11.id", 32'(dut.s1_test_id), 32'd11);
    check("s1v11.found", 32'(dut.s1_found), 32'd0);
    tick(1);
    check("s1v12.found", 32'(dut.s1_found), 32'd1);
    check("s1v12.index", 32'(dut.s1_index), 32'd12);
    tick(3);
    check("c47.s_ok", 32'(dut.tlb_s_test_ok), 32'd0);
    tick(1);
    check_flags("c48", 1'b1, 1'b1, 1'b1);
    check("c48.err", 32'(dut.test_error), 32'd0);
    tick(20);
    check_flags("done_hold", 1'b1, 1'b1, 1'b1);
    check("done_hold.err", 32'(dut.test_error), 32'd0);
    check("done_hold.s1_id", 32'(dut.s1_test_id), 32'd16);

    // Reset mid read phase, then a full rerun.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
    tick(20);
    check("mid.r_cnt", 32'(dut.tlb_r_cnt), 32'd4);
    check("mid.w_ok", 32'(dut.tlb_w_test_ok), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    check("mid_rst.r_cnt", 32'(dut.tlb_r_cnt), 32'd0);
    check("mid_rst.tlb_pfn1[0]", 32'(dut.r_pfn1), 32'd0);
    repeat (3) @(negedge clk);
    release_reset();
    tick(16);
    check("rerun.c16.w_ok", 32'(dut.tlb_w_test_ok), 32'd1);
    tick(16);
    check("rerun.c32.r_ok", 32'(dut.tlb_r_test_ok), 32'd1);
    tick(16);
    check("rerun.c48.s_ok", 32'(dut.tlb_s_test_ok), 32'd1);
    check("rerun.err", 32'(dut.test_error), 32'd0);

    // Stored pfn0 of entry 3 stuck at zero; other entries hold their pattern.
    resetn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fault_pfn0[i*20 +: 20] = (i == 3) ? 20'h0 : 20'(i);
    end
    force dut.u_tlb.r_tlb_pfn0 = fault_pfn0;
    repeat (3) @(negedge clk);
    release_reset();
    tick(40);
    check("fault.err", 32'(dut.test_error), 32'd1);
    check("fault.r_cnt", 32'(dut.tlb_r_cnt), 32'd3);
    check_flags("fault", 1'b1, 1'b0, 1'b0);
    check("fault.s0_id", 32'(dut.s0_test_id), 32'd0);
    release dut.u_tlb.r_tlb_pfn0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
